// File: rtl/wb_commit_arbiter.sv
// Round-robin writeback arbiter: picks one requesting unit per cycle and registers
// its id/data/unit index as a commit packet one cycle later.
module wb_commit_arbiter #(
    parameter int NUM_UNITS = 4,
    parameter int ID_W      = 3,
    parameter int DATA_W    = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wb_suppress,
    input  logic [NUM_UNITS-1:0]          unit_valid,
    input  logic [NUM_UNITS*ID_W-1:0]     unit_id,
    input  logic [NUM_UNITS*DATA_W-1:0]   unit_data,
    output logic [NUM_UNITS-1:0]          unit_ack,
    output logic                          commit_valid,
    output logic [ID_W-1:0]               commit_id,
    output logic [DATA_W-1:0]             commit_data,
    output logic [$clog2(NUM_UNITS)-1:0]  commit_unit
);

    localparam int PTR_W = $clog2(NUM_UNITS);
    localparam logic [PTR_W:0] NUM_UNITS_W = (PTR_W+1)'(NUM_UNITS);
    localparam logic [PTR_W-1:0] LAST_UNIT = PTR_W'(NUM_UNITS - 1);

    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic              commit_valid_q, commit_valid_d;
    logic [ID_W-1:0]   commit_id_q, commit_id_d;
    logic [DATA_W-1:0] commit_data_q, commit_data_d;
    logic [PTR_W-1:0]  commit_unit_q, commit_unit_d;

    logic [ID_W-1:0]   id_arr   [NUM_UNITS];
    logic [DATA_W-1:0] data_arr [NUM_UNITS];

    logic              grant_found;
    logic [PTR_W-1:0]  grant_idx;
    logic [PTR_W:0]    cand_sum;

    for (genvar k = 0; k < NUM_UNITS; k++) begin : g_unpack
        assign id_arr[k]   = unit_id[k*ID_W +: ID_W];
        assign data_arr[k] = unit_data[k*DATA_W +: DATA_W];
    end

    // Cyclic search starting at rr_ptr; the extra sum bit lets non-power-of-two
    // unit counts wrap correctly.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand_sum    = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            cand_sum = {1'b0, rr_ptr_q} + (PTR_W+1)'(i);
            if (cand_sum >= NUM_UNITS_W) begin
                cand_sum = cand_sum - NUM_UNITS_W;
            end
            if (!grant_found && unit_valid[cand_sum[PTR_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand_sum[PTR_W-1:0];
            end
        end
        if (rst || wb_suppress) begin
            grant_found = 1'b0;
        end
    end

    always_comb begin
        unit_ack = '0;
        if (grant_found) begin
            unit_ack[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        rr_ptr_d       = rr_ptr_q;
        commit_valid_d = 1'b0;
        commit_id_d    = commit_id_q;
        commit_data_d  = commit_data_q;
        commit_unit_d  = commit_unit_q;
        if (grant_found) begin
            rr_ptr_d       = (grant_idx == LAST_UNIT) ? '0 : grant_idx + PTR_W'(1);
            commit_valid_d = 1'b1;
            commit_id_d    = id_arr[grant_idx];
            commit_data_d  = data_arr[grant_idx];
            commit_unit_d  = grant_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q       <= '0;
            commit_valid_q <= 1'b0;
            commit_id_q    <= '0;
            commit_data_q  <= '0;
            commit_unit_q  <= '0;
        end else begin
            rr_ptr_q       <= rr_ptr_d;
            commit_valid_q <= commit_valid_d;
            commit_id_q    <= commit_id_d;
            commit_data_q  <= commit_data_d;
            commit_unit_q  <= commit_unit_d;
        end
    end

    assign commit_valid = commit_valid_q;
    assign commit_id    = commit_id_q;
    assign commit_data  = commit_data_q;
    assign commit_unit  = commit_unit_q;

endmodule

// File: tb/tb_wb_commit_arbiter.sv
// Bench for wb_commit_arbiter: directed scenarios plus randomized hold-until-ack
// traffic checked against a behavioural round-robin model and per-unit scoreboard.
module tb_wb_commit_arbiter;

    localparam int N  = 4;
    localparam int IW = 3;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            wb_suppress;
    logic [N-1:0]    unit_valid;
    logic [N*IW-1:0] unit_id;
    logic [N*DW-1:0] unit_data;
    logic [N-1:0]    unit_ack;
    logic            commit_valid;
    logic [IW-1:0]   commit_id;
    logic [DW-1:0]   commit_data;
    logic [1:0]      commit_unit;

    int checks   = 0;
    int failures = 0;

    // behavioural model state
    int            m_ptr   = 0;
    logic          m_cv    = 1'b0;
    logic [IW-1:0] m_cid   = '0;
    logic [DW-1:0] m_cdata = '0;
    int            m_cunit = 0;

    typedef struct {
        int            unit;
        logic [IW-1:0] id;
        logic [DW-1:0] data;
    } sb_t;
    sb_t sbq[$];

    wb_commit_arbiter #(.NUM_UNITS(N), .ID_W(IW), .DATA_W(DW)) dut (
        .clk          (clk),
        .rst          (rst),
        .wb_suppress  (wb_suppress),
        .unit_valid   (unit_valid),
        .unit_id      (unit_id),
        .unit_data    (unit_data),
        .unit_ack     (unit_ack),
        .commit_valid (commit_valid),
        .commit_id    (commit_id),
        .commit_data  (commit_data),
        .commit_unit  (commit_unit)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // First requester at or after ptr, wrapping; -1 when nothing may be granted.
    function automatic int exp_grant(input logic [N-1:0] v, input int ptr,
                                     input logic sup, input logic r);
        if (r || sup) return -1;
        for (int j = 0; j < N; j++) begin
            if (v[(ptr + j) % N]) return (ptr + j) % N;
        end
        return -1;
    endfunction

    task automatic set_req(input int k, input logic [IW-1:0] id, input logic [DW-1:0] data);
        unit_id[k*IW +: IW]   = id;
        unit_data[k*DW +: DW] = data;
    endtask

    // Called ~1 time unit after an edge with inputs already driven; returns the grant.
    task automatic step(output int g);
        logic [IW-1:0] nid;
        logic [DW-1:0] ndata;
        #1;
        g = exp_grant(unit_valid, m_ptr, wb_suppress, rst);
        chk("ack", {60'd0, unit_ack}, (g >= 0) ? (64'd1 << g) : 64'd0);
        nid   = '0;
        ndata = '0;
        if (g >= 0) begin
            nid   = unit_id[g*IW +: IW];
            ndata = unit_data[g*DW +: DW];
        end
        @(posedge clk);
        #1;
        if (rst) begin
            m_ptr = 0; m_cv = 1'b0; m_cid = '0; m_cdata = '0; m_cunit = 0;
        end else if (g >= 0) begin
            m_ptr = (g + 1) % N; m_cv = 1'b1; m_cid = nid; m_cdata = ndata; m_cunit = g;
        end else begin
            m_cv = 1'b0;
        end
        chk("commit_valid", {63'd0, commit_valid}, {63'd0, m_cv});
        chk("commit_id", {61'd0, commit_id}, {61'd0, m_cid});
        chk("commit_data", {32'd0, commit_data}, {32'd0, m_cdata});
        chk("commit_unit", {62'd0, commit_unit}, 64'(m_cunit));
    endtask

    initial begin
        int g;
        int order [8];
        logic          pending  [N];
        int            waitc    [N];
        logic [IW-1:0] rid      [N];
        logic [DW-1:0] rdata    [N];
        int            found;

        rst = 1'b1; wb_suppress = 1'b0; unit_valid = 4'b1111;
        unit_id = '0; unit_data = '0;

        // reset: no ack while rst high, commit registers cleared
        step(g);
        step(g);
        chk("rst_ack", {60'd0, unit_ack}, 64'd0);
        chk("rst_cv", {63'd0, commit_valid}, 64'd0);
        chk("rst_cdata", {32'd0, commit_data}, 64'd0);

        // two requesters: unit1 then unit3, pointer back at 0
        rst = 1'b0; unit_valid = 4'b1010;
        set_req(1, 3'd1, 32'h1111_0001); set_req(3, 3'd3, 32'h3333_0003);
        step(g);
        chk("r30_g0", 64'(g), 64'd1);
        chk("r30_cu0", {62'd0, commit_unit}, 64'd1);
        step(g);
        chk("r30_g1", 64'(g), 64'd3);
        chk("r30_cu1", {62'd0, commit_unit}, 64'd3);

        // all requesting with fresh data: strict rotation from 0
        order = '{0, 1, 2, 3, 0, 1, 2, 3};
        unit_valid = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            for (int k = 0; k < N; k++) set_req(k, IW'($urandom), $urandom);
            step(g);
            chk("r31_order", 64'(g), 64'(order[c]));
            chk("r31_cv", {63'd0, commit_valid}, 64'd1);
        end

        // steer pointer to 3, then unit2 must still win
        unit_valid = 4'b0100; set_req(2, 3'd2, 32'h0);
        step(g);
        set_req(2, 3'd5, 32'hDEADBEEF);
        step(g);
        chk("r32_g", 64'(g), 64'd2);
        chk("r32_cid", {61'd0, commit_id}, 64'd5);
        chk("r32_cdata", {32'd0, commit_data}, 64'hDEADBEEF);
        chk("r32_cu", {62'd0, commit_unit}, 64'd2);

        // suppress blocks everything, release grants immediately
        unit_valid = 4'b0001; set_req(0, 3'd6, 32'hA5A5_0000); wb_suppress = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step(g);
            chk("r33_cv", {63'd0, commit_valid}, 64'd0);
        end
        wb_suppress = 1'b0;
        step(g);
        chk("r33_g", 64'(g), 64'd0);
        chk("r33_cv_rel", {63'd0, commit_valid}, 64'd1);
        chk("r33_cid", {61'd0, commit_id}, 64'd6);

        // mid-stream reset with pointer at 2
        unit_valid = 4'b0010; set_req(1, 3'd7, 32'h7);
        step(g);
        unit_valid = 4'b1111; rst = 1'b1;
        step(g);
        chk("r34_cv", {63'd0, commit_valid}, 64'd0);
        rst = 1'b0;
        step(g);
        chk("r34_g", 64'(g), 64'd0);

        // randomized hold-until-ack traffic
        unit_valid = '0;
        step(g);
        for (int k = 0; k < N; k++) begin pending[k] = 1'b0; waitc[k] = 0; end
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < N; k++) begin
                if (!pending[k] && $urandom_range(0, 2) != 0) begin
                    pending[k] = 1'b1; waitc[k] = 0;
                    rid[k] = IW'($urandom); rdata[k] = $urandom;
                    sbq.push_back('{unit: k, id: rid[k], data: rdata[k]});
                end
                unit_valid[k] = pending[k];
                set_req(k, pending[k] ? rid[k] : IW'($urandom), pending[k] ? rdata[k] : $urandom);
                if (pending[k]) waitc[k]++;
            end
            step(g);
            if (g >= 0) begin
                chk("fair_wait", {63'd0, waitc[g] <= N}, 64'd1);
                pending[g] = 1'b0;
            end
            if (commit_valid) begin
                found = -1;
                for (int i = 0; i < sbq.size(); i++) begin
                    if (found < 0 && sbq[i].unit == int'(commit_unit)) found = i;
                end
                chk("sb_present", {63'd0, found >= 0}, 64'd1);
                if (found >= 0) begin
                    chk("sb_id", {61'd0, commit_id}, {61'd0, sbq[found].id});
                    chk("sb_data", {32'd0, commit_data}, {32'd0, sbq[found].data});
                    sbq.delete(found);
                end
            end
        end
        // drain: outstanding requests keep valid until acked
        for (int c = 0; c < N + 2; c++) begin
            for (int k = 0; k < N; k++) unit_valid[k] = pending[k];
            step(g);
            if (g >= 0) pending[g] = 1'b0;
            if (commit_valid) begin
                found = -1;
                for (int i = 0; i < sbq.size(); i++) begin
                    if (found < 0 && sbq[i].unit == int'(commit_unit)) found = i;
                end
                chk("drain_present", {63'd0, found >= 0}, 64'd1);
                if (found >= 0) begin
                    chk("drain_id", {61'd0, commit_id}, {61'd0, sbq[found].id});
                    chk("drain_data", {32'd0, commit_data}, {32'd0, sbq[found].data});
                    sbq.delete(found);
                end
            end
        end
        chk("sb_empty", 64'(sbq.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_commit_arbiter.md
WB_COMMIT_ARBITER -- requirements
Module: wb_commit_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_UNITS, default 4, giving the number of writeback requesters (legal range 2..8).
REQ-002 The block SHALL have parameter ID_W, default 3, giving the width of an instruction id (LOG2_MAX_IDS).
REQ-003 The block SHALL have parameter DATA_W, default 32, giving the writeback data width (MAX_POSSIBLE_REG_BITS).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port wb_suppress, input, 1 bit: the global-control writeback suppress, which blocks all grants while high.
REQ-007 The block SHALL have port unit_valid, input, NUM_UNITS bits: per-unit writeback request.
REQ-008 The block SHALL have port unit_id, input, NUM_UNITS*ID_W bits: per-unit instruction id; unit k occupies bits [k*ID_W +: ID_W].
REQ-009 The block SHALL have port unit_data, input, NUM_UNITS*DATA_W bits: per-unit result, packed the same way as unit_id.
REQ-010 The block SHALL have port unit_ack, output, NUM_UNITS bits: per-unit grant, combinational, at most one bit high.
REQ-011 The block SHALL have port commit_valid, output, 1 bit: a registered commit packet is valid.
REQ-012 The block SHALL have port commit_id, output, ID_W bits: the registered id of the granted request.
REQ-013 The block SHALL have port commit_data, output, DATA_W bits: the registered data of the granted request.
REQ-014 The block SHALL have port commit_unit, output, $clog2(NUM_UNITS) bits: the registered index of the granted unit.

Function
REQ-015 The block SHALL hold a round-robin pointer rr_ptr of width $clog2(NUM_UNITS).
REQ-016 Each cycle, with wb_suppress low, the block SHALL grant the first k with unit_valid[k]=1, searching cyclically from rr_ptr upward and wrapping NUM_UNITS-1 -> 0.
REQ-017 unit_ack[k] SHALL assert in the same cycle as the grant to k; it is a pure function of unit_valid, rr_ptr and wb_suppress.
REQ-018 On a grant to k, rr_ptr SHALL update to (k+1) mod NUM_UNITS at the next edge; with no grant, rr_ptr SHALL hold.
REQ-019 On a grant to k, commit_valid SHALL be 1 at the next edge, with commit_id, commit_data and commit_unit taken from unit k; fixed latency of 1 cycle.
REQ-020 With no grant, commit_valid SHALL be 0 at the next edge, and commit_id, commit_data and commit_unit SHALL hold their previous values.
REQ-021 A requester SHALL hold unit_valid, unit_id and unit_data stable until acked; the bench asserts this and the block need not tolerate violations.
REQ-022 A requester may present a new request in the cycle after its ack; the block SHALL treat it as a fresh request with no bubble.
REQ-023 While wb_suppress=1, unit_ack SHALL be all zeros, commit_valid SHALL be 0 at the next edge, and rr_ptr SHALL hold.
REQ-024 Fairness: with wb_suppress low, a continuously held request SHALL be granted within NUM_UNITS cycles.
REQ-025 With all units requesting every cycle, grants SHALL rotate strictly rr_ptr, rr_ptr+1, ... with one grant per cycle.
REQ-026 At most one commit packet SHALL be produced per cycle; commit has no backpressure.

Reset
REQ-027 With rst=1 at an edge, the block SHALL set rr_ptr=0, commit_valid=0, commit_id=0, commit_data=0 and commit_unit=0.
REQ-028 While rst=1, unit_ack SHALL be all zeros, regardless of unit_valid.
REQ-029 Reset asserted mid-stream SHALL discard any pending grant; after reset is released, arbitration SHALL restart from unit 0.

Verification
REQ-030 After reset, unit_valid=4'b1010 held -> ack unit1 in cycle 0 and unit3 in cycle 1; commit_unit=1 then 3, each one cycle later; rr_ptr ends at 0.
REQ-031 unit_valid=4'b1111 with fresh data every cycle for 8 cycles -> grant order 0,1,2,3,0,1,2,3; commit_valid=1 continuously from cycle 1.
REQ-032 unit2 requests with id=5 and data=32'hDEADBEEF, rr_ptr=3 -> unit_ack=4'b0100; next cycle commit_valid=1, commit_id=5, commit_data=32'hDEADBEEF, commit_unit=2.
REQ-033 wb_suppress=1 for 3 cycles with unit_valid=4'b0001 -> unit_ack=0 and commit_valid=0 throughout; on release, unit0 is acked the same cycle and commits the next cycle.
REQ-034 rst pulsed for 1 cycle while rr_ptr=2 and unit_valid=4'b1111 -> commit_valid=0 and no ack during reset; the first post-reset grant goes to unit0.
REQ-035 Random stimulus with the hold-until-ack protocol -> every request is committed exactly once, in order per unit, with wait <= NUM_UNITS cycles.
